// File: rtl/ifetch_queue_if.sv
// Instruction bus between the fetch queue (master) and instruction memory (slave).
//   bus_cyc  master->slave  read cycle active
//   bus_adr  master->slave  read word address
//   bus_ack  slave->master  read data valid
//   bus_in   slave->master  read data
interface ifetch_queue_if #(
  parameter int unsigned AWIDTH = 32
) ();
  logic              bus_cyc;
  logic [AWIDTH-1:0] bus_adr;
  logic              bus_ack;
  logic [31:0]       bus_in;

  modport master (output bus_cyc, output bus_adr, input bus_ack, input bus_in);
  modport slave  (input bus_cyc, input bus_adr, output bus_ack, output bus_in);
endinterface

// File: rtl/ifetch_queue.sv
// Prefetching instruction fetch front end. Issues sequential single-word reads on the
// instruction bus, buffers returned words in a DEPTH-entry FIFO and assembles short
// (one-word) or long (two-word, head[EXT_BIT]=1) instructions into a 64-bit ir.
// A pc_set redirect flushes the queue; a read in flight at that point completes and
// its data is discarded.
//
// Optional feature: define IFETCH_QUEUE_BYPASS_EN to present a short word on ir in the
// cycle it is acked when the queue is empty (otherwise data appears one cycle later).
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   pc_set, pc_in  redirect strobe and word-aligned target
//   stall_i        downstream stall; holds ir/pc, nothing is consumed
//   bus            instruction bus (master modport)
//   ir, pc, valid  assembled instruction, its address, and completeness flag
//   stall_o        !valid
module ifetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = '0,
  parameter int unsigned       EXT_BIT  = 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_set,
  input  logic [AWIDTH-1:0] pc_in,
  input  logic              stall_i,
  ifetch_queue_if.master    bus,
  output logic [63:0]       ir,
  output logic [AWIDTH-1:0] pc,
  output logic              valid,
  output logic              stall_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StBusy} fetch_st_e;

  fetch_st_e         st_q;
  logic [AWIDTH-1:0] fetch_pc_q, adr_q, head_pc_q;
  logic              drop_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]       mem_q [DEPTH];

  logic              ack, head_long, fifo_valid, bypass, byp_take, pop, push;
  logic [31:0]       head_word, second_word;
  logic [CntW-1:0]   pop_cnt, count_nxt;
  logic [AWIDTH-1:0] head_adv;

  assign bus.bus_cyc = (st_q == StBusy);
  assign bus.bus_adr = adr_q;

  always_comb begin
    ack         = bus.bus_ack && (st_q == StBusy);
    head_word   = mem_q[rd_ptr_q];
    second_word = mem_q[rd_ptr_q + PtrW'(1)];
    head_long   = head_word[EXT_BIT];
    fifo_valid  = (count_q >= CntW'(1) && !head_long) || (count_q >= CntW'(2) && head_long);
`ifdef IFETCH_QUEUE_BYPASS_EN
    bypass      = ack && !drop_q && !pc_set && (count_q == '0) && !bus.bus_in[EXT_BIT];
`else
    bypass      = 1'b0;
`endif
    byp_take    = bypass && !stall_i;
    pop         = fifo_valid && !stall_i;
    // A bypassed word that is consumed immediately never enters the FIFO.
    push        = ack && !drop_q && !pc_set && !byp_take;
    pop_cnt     = pop ? (head_long ? CntW'(2) : CntW'(1)) : '0;
    count_nxt   = count_q + CntW'(push) - pop_cnt;
    head_adv    = pop ? (head_long ? AWIDTH'(8) : AWIDTH'(4)) :
                  (byp_take ? AWIDTH'(4) : '0);
  end

  always_comb begin
    ir    = 64'h0;
    pc    = head_pc_q;
    valid = fifo_valid || bypass;
    if (fifo_valid) begin
      ir = head_long ? {head_word, second_word} : {head_word, 32'h0};
    end else if (bypass) begin
      ir = {bus.bus_in, 32'h0};
      pc = fetch_pc_q;
    end
    stall_o = !valid;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.bus_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q       <= StIdle;
      adr_q      <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      if (pc_set) begin
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        head_pc_q  <= pc_in;
        fetch_pc_q <= pc_in;
      end else begin
        count_q   <= count_nxt;
        head_pc_q <= head_pc_q + head_adv;
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + (head_long ? PtrW'(2) : PtrW'(1));
        if (ack && !drop_q) fetch_pc_q <= fetch_pc_q + AWIDTH'(4);
      end

      unique case (st_q)
        StIdle: begin
          if (!pc_set && count_q < DepthC) begin
            st_q  <= StBusy;
            adr_q <= fetch_pc_q;
          end
        end
        StBusy: begin
          if (ack) begin
            drop_q <= 1'b0;
            if (pc_set) begin
              st_q <= StIdle;
            end else if (drop_q) begin
              // Stale read retired; fetch_pc already holds the redirect target.
              adr_q <= fetch_pc_q;
            end else if (count_nxt < DepthC) begin
              adr_q <= fetch_pc_q + AWIDTH'(4);
            end else begin
              st_q <= StIdle;
            end
          end else if (pc_set) begin
            // No bus abort: let the read finish and throw its data away.
            drop_q <= 1'b1;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam int LAT      = 0;
  localparam int LONG_GAP = 3;
`else
  localparam int LAT      = 1;
  localparam int LONG_GAP = 2;
`endif
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pc_set = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        stall_i = 1'b0;
  logic [63:0] ir;
  logic [31:0] pc;
  logic        valid, stall_o;

  ifetch_queue_if #(.AWIDTH(32)) bus ();

  ifetch_queue #(.DEPTH(4), .AWIDTH(32), .RESET_PC(RESET_PC), .EXT_BIT(31)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pc_set  (pc_set),
    .pc_in   (pc_in),
    .stall_i (stall_i),
    .bus     (bus),
    .ir      (ir),
    .pc      (pc),
    .valid   (valid),
    .stall_o (stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] ir;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] gen_pc;
  logic [31:0] ovr [logic [31:0]];
  int          tests = 0, fails = 0, cyc_n = 0, consumed = 0;
  int          first_ack = -1, first_valid = -1;
  int          cons_cyc[$];
  int          wait_fixed = 0, wait_left = 0;
  logic        prev_ack = 1'b0, prev_cyc = 1'b0;
  logic        flush_on_ack = 1'b0;
  logic [31:0] flush_tgt = 32'h0;

  // Instruction memory image: directed overrides, else a hashed pattern (~1/4 long).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (ovr.exists(a)) return ovr[a];
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 13) ^ 32'h1234_5678;
    return {h[7:6] == 2'b00, h[30:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the instruction stream is decoded straight from memory at gen_pc.
  task automatic push_exp();
    logic [31:0] w0;
    exp_t e;
    w0 = mem_word(gen_pc);
    e.pc = gen_pc;
    if (w0[31]) begin
      e.ir = {w0, mem_word(gen_pc + 32'd4)};
      gen_pc = gen_pc + 32'd8;
    end else begin
      e.ir = {w0, 32'h0};
      gen_pc = gen_pc + 32'd4;
    end
    exp_q.push_back(e);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    exp_q.delete();
    gen_pc = tgt;
    repeat (8) push_exp();
  endtask

  // One clock: bus slave answers after a (fixed or random) wait per request.
  task automatic step();
    @(posedge clk_i);
    #1;
    pc_set = 1'b0;
    if (bus.bus_cyc) begin
      if (prev_ack || !prev_cyc)
        wait_left = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(3, 0));
      if (wait_left == 0) begin
        bus.bus_ack = 1'b1;
        bus.bus_in  = mem_word(bus.bus_adr);
      end else begin
        bus.bus_ack = 1'b0;
        bus.bus_in  = $urandom;
        wait_left--;
      end
    end else begin
      bus.bus_ack = 1'b0;
      bus.bus_in  = $urandom;
    end
    prev_ack = bus.bus_ack;
    prev_cyc = bus.bus_cyc;
    if (flush_on_ack && bus.bus_ack) begin
      pc_set = 1'b1;
      pc_in  = flush_tgt;
      redirect(flush_tgt);
      flush_on_ack = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard on every consumed instruction.
  exp_t        mon_e;
  logic        hold_v = 1'b0;
  logic [63:0] hold_ir;
  logic [31:0] hold_pc;
  always @(negedge clk_i) begin
    cyc_n++;
    if (rst_i) begin
      hold_v = 1'b0;
    end else begin
      if (bus.bus_cyc && bus.bus_ack && first_ack < 0) first_ack = cyc_n;
      if (valid && first_valid < 0) first_valid = cyc_n;
      check("stall_o", {63'h0, stall_o}, {63'h0, !valid});
      if (hold_v) begin
        check("hold_valid", {63'h0, valid}, 64'h1);
        check("hold_ir", ir, hold_ir);
        check("hold_pc", {32'h0, pc}, {32'h0, hold_pc});
      end
      if (valid && !stall_i && !pc_set) begin
        while (exp_q.size() < 4) push_exp();
        mon_e = exp_q.pop_front();
        check("ir", ir, mon_e.ir);
        check("pc", {32'h0, pc}, {32'h0, mon_e.pc});
        consumed++;
        if (cons_cyc.size() < 3) cons_cyc.push_back(cyc_n);
      end
      hold_v  = valid && stall_i && !pc_set;
      hold_ir = ir;
      hold_pc = pc;
    end
  end

  initial begin
    logic got;
    logic [31:0] tgt;
    bus.bus_ack = 1'b0;
    bus.bus_in  = 32'h0;
    ovr[32'h00] = 32'h0100_0000;
    ovr[32'h04] = 32'h0200_0000;
    ovr[32'h08] = 32'h8000_0001;
    ovr[32'h0C] = 32'hDEAD_BEEF;
    ovr[32'h10] = 32'h0300_0000;
    ovr[32'h14] = 32'h0400_0000;

    // Reset state
    #12;
    check("rst_cyc", {63'h0, bus.bus_cyc}, 64'h0);
    check("rst_adr", {32'h0, bus.bus_adr}, {32'h0, RESET_PC});
    check("rst_valid", {63'h0, valid}, 64'h0);
    check("rst_ir", ir, 64'h0);
    check("rst_pc", {32'h0, pc}, {32'h0, RESET_PC});
    check("rst_stall_o", {63'h0, stall_o}, 64'h1);

    // Straight-line code and a long instruction, zero-wait memory
    wait_fixed = 0;
    step();
    rst_i = 1'b0;
    redirect(RESET_PC);
    first_ack = -1;
    first_valid = -1;
    cons_cyc.delete();
    repeat (10) step();
    check("saw_valid", {63'h0, first_valid >= 0}, 64'h1);
    check("latency", 64'(first_valid - first_ack), 64'(LAT));
    check("cons_count", {63'h0, cons_cyc.size() >= 3}, 64'h1);
    if (cons_cyc.size() >= 3) begin
      check("short_rate", 64'(cons_cyc[1] - cons_cyc[0]), 64'h1);
      check("long_gap", 64'(cons_cyc[2] - cons_cyc[1]), 64'(LONG_GAP));
    end

    // Stall until full, then drain
    stall_i = 1'b1;
    repeat (10) step();
    check("full_cyc_idle", {63'h0, bus.bus_cyc}, 64'h0);
    stall_i = 1'b0;
    repeat (20) step();

    // Flush with a read outstanding
    wait_fixed = 3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = bus.bus_cyc && !bus.bus_ack;
    end
    check("outstanding_found", {63'h0, got}, 64'h1);
    pc_set = 1'b1;
    pc_in  = 32'h100;
    redirect(32'h100);
    step();
    #1;
    check("flush_valid0", {63'h0, valid}, 64'h0);
    got = bus.bus_ack;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = bus.bus_ack;
    end
    check("stale_ack_seen", {63'h0, got}, 64'h1);
    step();
    check("refetch_cyc", {63'h0, bus.bus_cyc}, 64'h1);
    check("refetch_adr", {32'h0, bus.bus_adr}, 64'h100);
    wait_fixed = -1;
    repeat (20) step();

    // pc_set together with bus_ack, then asynchronous reset mid-fetch
    wait_fixed = 2;
    flush_tgt = 32'h200;
    flush_on_ack = 1'b1;
    for (int i = 0; i < 20 && flush_on_ack; i++) step();
    check("flush_ack_hit", {63'h0, flush_on_ack}, 64'h0);
    step();
    #1;
    check("flush_ack_valid0", {63'h0, valid}, 64'h0);
    repeat (8) step();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = bus.bus_cyc && !bus.bus_ack;
    end
    check("midfetch_found", {63'h0, got}, 64'h1);
    #1;
    rst_i = 1'b1;
    #1;
    check("arst_cyc", {63'h0, bus.bus_cyc}, 64'h0);
    check("arst_valid", {63'h0, valid}, 64'h0);
    check("arst_adr", {32'h0, bus.bus_adr}, {32'h0, RESET_PC});
    check("arst_stall_o", {63'h0, stall_o}, 64'h1);
    step();
    step();
    rst_i = 1'b0;
    redirect(RESET_PC);
    // Late ack while no cycle is active must be ignored.
    bus.bus_ack = 1'b1;
    bus.bus_in  = 32'h0BAD_0000;
    repeat (20) step();

    // Random traffic: stalls, waits, redirects (one near the top of the address space)
    wait_fixed = -1;
    for (int i = 0; i < 3000; i++) begin
      step();
      stall_i = ($urandom_range(99, 0) < 30);
      if (i == 1000 || $urandom_range(99, 0) < 2) begin
        tgt = (i == 1000) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_3FFC);
        pc_set = 1'b1;
        pc_in  = tgt;
        redirect(tgt);
      end
    end
    stall_i = 1'b0;
    repeat (5) step();
    check("progress", {63'h0, consumed > 500}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
